des_subkey_gen: RTL and testbench



---
 rtl/des_subkey_gen.sv | 210 +++++++++++++++++++++
 tb/tb_des_subkey_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_subkey_gen.sv
// DES key schedule: PC-1 once per schedule, per-round 28-bit C/D rotation,
// PC-2 per subkey. Emits K1..K16 (encrypt) or K16..K1 (decrypt) one per
// valid/ready handshake.
// Optional build macro: DES_WEAK_KEY_DET_EN (flags the four DES weak keys).
module des_subkey_gen #(
    // bit i-1 = round i; 1 = single-bit rotate, 0 = double-bit rotate.
    // Standard DES: rounds 1, 2, 9 and 16 rotate by one, 28 positions in total.
    parameter logic [15:0] SHIFT_SCHED = 16'b1000_0001_0000_0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic        ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        done,
    output logic        weak_key
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES bit n of the key lives at key_in[64-n]; output bit 1 lands at [55].
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1_TAB[i]];
        end
        return r;
    endfunction

    // CD bit n lives at cd[56-n]; subkey bit 1 lands at [47].
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2_TAB[i]];
        end
        return r;
    endfunction

    // 28-bit circular rotate, left or right, by one or two positions.
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic right,
                                          input logic two);
        logic [27:0] r;
        case ({right, two})
            2'b00:   r = {x[26:0], x[27]};
            2'b01:   r = {x[25:0], x[27:26]};
            2'b10:   r = {x[0], x[27:1]};
            default: r = {x[1:0], x[27:2]};
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        dec_q, dec_d;
    logic [47:0] subkey_q, subkey_d;
    logic        vld_q, vld_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;

    logic [55:0] cd0;
    logic [27:0] c0, d0;
    logic [27:0] c_n, d_n;
    logic [3:0]  sidx;

    // Parity bits (DES bits 8, 16, ..., 64) play no part in the schedule.
    logic        key_parity_unused;
    assign key_parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                 key_in[24], key_in[16], key_in[8],  key_in[0]};

    assign cd0 = pc1(key_in);
    assign c0  = cd0[55:28];
    assign d0  = cd0[27:0];

`ifdef DES_WEAK_KEY_DET_EN
    logic weak_q, weak_d;
    assign weak_key = weak_q;
`else
    assign weak_key = 1'b0;
`endif

    // Next-state: load and first rotate on start, one rotate per accepted subkey.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        dec_d    = dec_q;
        subkey_d = subkey_q;
        vld_d    = vld_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        c_n      = c_q;
        d_n      = d_q;
        sidx     = 4'd0;
`ifdef DES_WEAK_KEY_DET_EN
        weak_d   = weak_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dec_d = decrypt;
                    // Decrypt starts from C16/D16, which equals C0/D0 after the full 28-bit wrap.
                    if (decrypt) begin
                        c_n = c0;
                        d_n = d0;
                    end else begin
                        c_n = rot28(c0, 1'b0, !SHIFT_SCHED[0]);
                        d_n = rot28(d0, 1'b0, !SHIFT_SCHED[0]);
                    end
                    c_d      = c_n;
                    d_d      = d_n;
                    subkey_d = pc2({c_n, d_n});
                    vld_d    = 1'b1;
                    idx_d    = 4'd0;
                    state_d  = ST_OUT;
`ifdef DES_WEAK_KEY_DET_EN
                    weak_d   = ((c0 == 28'h0) || (c0 == 28'hFFFFFFF)) &&
                               ((d0 == 28'h0) || (d0 == 28'hFFFFFFF));
`endif
                end
            end
            ST_OUT: begin
                if (vld_q && subkey_ready) begin
                    if (idx_q == 4'd15) begin
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        // Encrypt position p uses round p+1; decrypt position p undoes round 17-p.
                        sidx  = dec_q ? (4'd15 - idx_q) : (idx_q + 4'd1);
                        c_n   = rot28(c_q, dec_q, !SHIFT_SCHED[sidx]);
                        d_n   = rot28(d_q, dec_q, !SHIFT_SCHED[sidx]);
                        c_d      = c_n;
                        d_d      = d_n;
                        subkey_d = pc2({c_n, d_n});
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            c_q      <= '0;
            d_q      <= '0;
            dec_q    <= 1'b0;
            subkey_q <= '0;
            vld_q    <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
`ifdef DES_WEAK_KEY_DET_EN
            weak_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            dec_q    <= dec_d;
            subkey_q <= subkey_d;
            vld_q    <= vld_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
`ifdef DES_WEAK_KEY_DET_EN
            weak_q   <= weak_d;
`endif
        end
    end

    assign ready        = (state_q == ST_IDLE);
    assign subkey       = subkey_q;
    assign subkey_valid = vld_q;
    assign round_idx    = idx_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Randomized self-checking bench for des_subkey_gen against a reference
// key schedule built from cumulative left-shift totals.
module tb_des_subkey_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        done;
    logic        weak_key;

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] exp_keys [16];
    logic [47:0] obs [16];
    logic [47:0] enc [16];
    logic        exp_weak;

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    des_subkey_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .ready        (ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .done         (done),
        .weak_key     (weak_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    // Reference: Kr = PC2(C0 <<< total_r, D0 <<< total_r); decrypt is the reversed list.
    function automatic void build(input logic [63:0] key, input bit dec);
        logic [55:0] cd;
        logic [55:0] cr;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] k;
        int tot;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot = tot + SHIFTS[r];
            cr = {rotl(c, tot % 28), rotl(d, tot % 28)};
            for (int i = 0; i < 48; i++) k[47-i] = cr[56-PC2[i]];
            ks[r] = k;
        end
        for (int i = 0; i < 16; i++) exp_keys[i] = dec ? ks[15-i] : ks[i];
`ifdef DES_WEAK_KEY_DET_EN
        exp_weak = ((c == 28'h0) || (c == 28'hFFFFFFF)) &&
                   ((d == 28'h0) || (d == 28'hFFFFFFF));
`else
        exp_weak = 1'b0;
`endif
    endfunction

    task automatic start_sched(input logic [63:0] key, input bit dec);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("start_vld", 64'(subkey_valid), 64'd1);
        check("start_rdy", 64'(ready), 64'd0);
        check("start_done", 64'(done), 64'd0);
        check("weak", 64'(weak_key), 64'(exp_weak));
    endtask

    // Accept stop_after subkeys, optionally with random stalls and an ignored mid-run start.
    task automatic collect(input bit stalls, input int stop_after);
        int acc;
        int cyc;
        bit acc_now;
        acc = 0;
        cyc = 0;
        while (acc < stop_after && cyc < 400) begin
            start = 1'b0;
            check("vld", 64'(subkey_valid), 64'd1);
            check("idx", 64'(round_idx), 64'(acc));
            check("key", 64'(subkey), 64'(exp_keys[acc]));
            check("done_mid", 64'(done), 64'd0);
            obs[acc] = subkey;
            subkey_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalls && cyc == 3) begin
                start   = 1'b1;
                key_in  = {$urandom, $urandom};
                decrypt = ~decrypt;
            end
            acc_now = subkey_valid & subkey_ready;
            tick();
            cyc++;
            if (acc_now) acc++;
        end
        start        = 1'b0;
        subkey_ready = 1'b0;
        check("accepts", 64'(acc), 64'(stop_after));
    endtask

    task automatic check_done();
        check("done", 64'(done), 64'd1);
        check("end_vld", 64'(subkey_valid), 64'd0);
        check("end_rdy", 64'(ready), 64'd1);
        check("end_idx", 64'(round_idx), 64'd15);
    endtask

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b0;
        exp_weak     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_rdy", 64'(ready), 64'd1);
        check("rst_vld", 64'(subkey_valid), 64'd0);
        check("rst_key", 64'(subkey), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_idx", 64'(round_idx), 64'd0);
        check("rst_weak", 64'(weak_key), 64'd0);

        // Encrypt order, no stalls.
        build(KEY, 1'b0);
        start_sched(KEY, 1'b0);
        collect(1'b0, 16);
        check_done();
        check("enc_k0", 64'(obs[0]), 64'h1B02EFFC7072);
        check("enc_k1", 64'(obs[1]), 64'h79AED9DBC9E5);
        check("enc_k15", 64'(obs[15]), 64'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) enc[i] = obs[i];
        tick();
        check("done_pulse", 64'(done), 64'd0);

        // Decrypt order, then restart in the done cycle with stalls.
        build(KEY, 1'b1);
        start_sched(KEY, 1'b1);
        collect(1'b0, 16);
        check_done();
        check("dec_k0", 64'(obs[0]), 64'hCB3D8B0E17F5);
        check("dec_k15", 64'(obs[15]), 64'h1B02EFFC7072);
        for (int i = 0; i < 16; i++) check("dec_rev", 64'(obs[i]), 64'(enc[15-i]));
        build(KEY, 1'b0);
        start_sched(KEY, 1'b0);
        collect(1'b1, 16);
        check_done();
        tick();
        check("done_pulse2", 64'(done), 64'd0);

        // Reset after 7 acceptances aborts the schedule.
        build(KEY, 1'b0);
        start_sched(KEY, 1'b0);
        collect(1'b1, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ab_rdy", 64'(ready), 64'd1);
        check("ab_vld", 64'(subkey_valid), 64'd0);
        check("ab_key", 64'(subkey), 64'd0);
        check("ab_done", 64'(done), 64'd0);
        check("ab_idx", 64'(round_idx), 64'd0);
        tick();
        check("ab_done2", 64'(done), 64'd0);
        start_sched(KEY, 1'b0);
        check("restart_k0", 64'(subkey), 64'h1B02EFFC7072);
        collect(1'b0, 16);
        check_done();
        tick();

        // Weak keys, then a normal key clears the flag.
        build(64'h0101010101010101, 1'b0);
        start_sched(64'h0101010101010101, 1'b0);
        collect(1'b0, 16);
        check_done();
        check("weak_zero_k", 64'(obs[9]), 64'd0);
        check("weak_hold", 64'(weak_key), 64'(exp_weak));
        tick();
        build(64'hFEFEFEFEFEFEFEFE, 1'b1);
        start_sched(64'hFEFEFEFEFEFEFEFE, 1'b1);
        collect(1'b1, 16);
        check_done();
        tick();
        build(KEY, 1'b0);
        start_sched(KEY, 1'b0);
        collect(1'b0, 16);
        check_done();
        tick();

        // Random keys, random direction, random stalls.
        for (int t = 0; t < 8; t++) begin
            logic [63:0] k;
            bit dir;
            k   = {$urandom, $urandom};
            dir = 1'($urandom_range(0, 1));
            build(k, dir);
            start_sched(k, dir);
            collect(1'b1, 16);
            check_done();
            tick();
            check("rnd_done_pulse", 64'(done), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
